// File: rtl/irq_controller.sv
// irq_controller: merges NUM_SRC peripheral requests onto one CPU interrupt line.
// Regs at BASE_ADDR+0..3: MASK, PENDING (W1C), VECTOR, EOI.
// Ports: CLK, RESET (sync, active-low), BUS_DATA/BUS_ADDR/BUS_WE bus,
//   SRC_RAISE/SRC_ACK per-source handshake, CPU_IRQ_RAISE/CPU_IRQ_ACK to CPU.
// Option: IRQ_ROUND_ROBIN_EN selects round-robin instead of lowest-index-wins.
module irq_controller #(
  parameter int          NUM_SRC   = 4,
  parameter logic [7:0]  BASE_ADDR = 8'hE0
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] SRC_RAISE,
  output logic [NUM_SRC-1:0] SRC_ACK,
  output logic               CPU_IRQ_RAISE,
  input  logic               CPU_IRQ_ACK
);

  typedef enum logic [1:0] {
    IDLE,
    RAISE,
    SERVICE
  } state_t;

  localparam logic [7:0] MASK_LIM =
    8'((1 << NUM_SRC) - 1);
  localparam logic [NUM_SRC-1:0] SRC_ONE =
    NUM_SRC'(1);

  state_t             state;
  logic [7:0]         mask_q;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] pend_nx;
  logic [NUM_SRC-1:0] src_ack;
  logic [NUM_SRC-1:0] cap;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] ack_clr;
  logic [7:0]         vector;
  logic [7:0]         rdata;
  logic [7:0]         rd_mux;
  logic [7:0]         pend8;
  logic [7:0]         off;
  logic               oe;
  logic               raise_q;
  logic               hit;
  logic               wr_mask;
  logic               wr_pend;
  logic               wr_eoi;
  logic [2:0]         win;
  logic               win_vld;
  logic               take;

  assign off     = BUS_ADDR - BASE_ADDR;
  assign hit     = off < 8'd4;
  assign wr_mask = hit && BUS_WE && off[1:0] == 2'd0;
  assign wr_pend = hit && BUS_WE && off[1:0] == 2'd1;
  assign wr_eoi  = hit && BUS_WE && off[1:0] == 2'd3;

  // Read data is registered; the enable is also gated with the live
  // address so the bus is released as soon as this block is not hit.
  assign BUS_DATA = (oe && hit && !BUS_WE) ? rdata : 8'hzz;

  assign SRC_ACK       = src_ack;
  assign CPU_IRQ_RAISE = raise_q;

  // A source still showing its ack this cycle is not recaptured.
  assign cap  = SRC_RAISE & ~pend & ~src_ack;
  assign elig = pend & mask_q[NUM_SRC-1:0];
  assign take = state == RAISE && CPU_IRQ_ACK && win_vld;

`ifdef IRQ_ROUND_ROBIN_EN
  localparam logic [3:0] NS = 4'(NUM_SRC);
  logic [2:0] ptr;
  logic [3:0] sum;

  // Search starts one past the last serviced id; the closest hit wins,
  // so scan from the farthest candidate down and keep overwriting.
  always_comb begin
    win     = '0;
    win_vld = |elig;
    sum     = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + 4'd1 + 4'(k);
      if (sum >= NS)
        sum = sum - NS;
      if (|(elig & (SRC_ONE << sum)))
        win = sum[2:0];
    end
  end
`else
  always_comb begin
    win     = '0;
    win_vld = |elig;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i])
        win = 3'(i);
  end
`endif

  assign ack_clr = take ? (SRC_ONE << win) : '0;

  // Capture is applied last so it beats a same-cycle W1C.
  always_comb begin
    pend_nx = pend & ~ack_clr;
    if (wr_pend)
      pend_nx = pend_nx & ~BUS_DATA[NUM_SRC-1:0];
    pend_nx = pend_nx | cap;
  end

  always_comb begin
    pend8 = '0;
    pend8[NUM_SRC-1:0] = pend;
  end

  always_comb begin
    rd_mux = '0;
    unique case (off[1:0])
      2'd0: rd_mux = mask_q;
      2'd1: rd_mux = pend8;
      2'd2: rd_mux = vector;
      2'd3: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= IDLE;
      mask_q  <= '0;
      pend    <= '0;
      src_ack <= '0;
      vector  <= '0;
      rdata   <= '0;
      oe      <= 1'b0;
      raise_q <= 1'b0;
`ifdef IRQ_ROUND_ROBIN_EN
      ptr     <= 3'(NUM_SRC - 1);
`endif
    end else begin
      src_ack <= cap;
      pend    <= pend_nx;
      oe      <= hit && !BUS_WE;
      rdata   <= rd_mux;
      if (wr_mask)
        mask_q <= BUS_DATA & MASK_LIM;
      unique case (state)
        IDLE: begin
          if (|elig) begin
            state   <= RAISE;
            raise_q <= 1'b1;
          end
        end
        RAISE: begin
          if (CPU_IRQ_ACK) begin
            raise_q <= 1'b0;
            if (win_vld) begin
              vector <= {1'b1, 4'b0, win};
              state  <= SERVICE;
`ifdef IRQ_ROUND_ROBIN_EN
              ptr    <= win;
`endif
            end else begin
              vector <= 8'h00;
              state  <= IDLE;
            end
          end else if (!(|elig)) begin
            state   <= IDLE;
            raise_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (wr_eoi) begin
            vector[7] <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed vectors plus a per-cycle reference model
// of the interrupt controller's register and handshake rules.
module tb_irq_controller;

  localparam int         N    = 4;
  localparam logic [7:0] BASE = 8'hE0;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  tri1  [7:0]   bus_data;
  logic [7:0]   addr  = 8'h00;
  logic [7:0]   wdata = 8'h00;
  logic         we    = 1'b0;
  logic         drv   = 1'b0;
  logic [N-1:0] raise = '0;
  logic [N-1:0] src_ack;
  logic         cpu_raise;
  logic         cpu_ack = 1'b0;

  int nvec = 0;
  int nerr = 0;
  bit live = 0;

  always #5 clk = ~clk;

  assign bus_data = drv ? wdata : 8'hzz;

  irq_controller #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
    .CLK          (clk),
    .RESET        (rst_n),
    .BUS_DATA     (bus_data),
    .BUS_ADDR     (addr),
    .BUS_WE       (we),
    .SRC_RAISE    (raise),
    .SRC_ACK      (src_ack),
    .CPU_IRQ_RAISE(cpu_raise),
    .CPU_IRQ_ACK  (cpu_ack)
  );

  // Reference model: phase 0 = quiet, 1 = asking the CPU, 2 = in service.
  logic [N-1:0] m_mask, m_pend, m_ack, n_mask, n_pend, n_ack;
  logic [7:0]   m_vec, m_rdata, n_vec, n_rdata;
  logic         m_oe, n_oe;
  int           m_phase, m_last, n_phase, n_last;

  function automatic int pick(logic [N-1:0] e, int last);
`ifdef IRQ_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++)
      if (e[(last + k) % N])
        return (last + k) % N;
`else
    for (int id = 0; id < N; id++)
      if (e[id])
        return id;
`endif
    return -1;
  endfunction

  always_comb begin
    logic [N-1:0] e;
    logic [7:0]   o;
    logic         h;
    int           w;
    e       = m_pend & m_mask;
    o       = 8'(addr - BASE);
    h       = o < 8'd4;
    w       = pick(e, m_last);
    n_mask  = m_mask;
    n_pend  = m_pend;
    n_vec   = m_vec;
    n_phase = m_phase;
    n_last  = m_last;
    if (h && we && o == 8'd0)
      n_mask = wdata[N-1:0];
    if (h && we && o == 8'd1)
      n_pend = n_pend & ~wdata[N-1:0];
    if (m_phase == 0) begin
      if (e != 0)
        n_phase = 1;
    end else if (m_phase == 1) begin
      if (cpu_ack) begin
        if (w >= 0) begin
          n_vec   = 8'h80 | 8'(w);
          n_pend  = n_pend & ~(N'(1) << w);
          n_last  = w;
          n_phase = 2;
        end else begin
          n_vec   = 8'h00;
          n_phase = 0;
        end
      end else if (e == 0) begin
        n_phase = 0;
      end
    end else begin
      if (h && we && o == 8'd3) begin
        n_vec   = m_vec & 8'h7F;
        n_phase = 0;
      end
    end
    n_ack  = raise & ~m_pend & ~m_ack;
    n_pend = n_pend | n_ack;
    n_oe   = h && !we;
    n_rdata = (o == 8'd0) ? 8'(m_mask) :
              (o == 8'd1) ? 8'(m_pend) :
              (o == 8'd2) ? m_vec : 8'h00;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mask  <= '0;
      m_pend  <= '0;
      m_ack   <= '0;
      m_vec   <= 8'h00;
      m_rdata <= 8'h00;
      m_oe    <= 1'b0;
      m_phase <= 0;
      m_last  <= N - 1;
      live    <= 1'b1;
    end else begin
      m_mask  <= n_mask;
      m_pend  <= n_pend;
      m_ack   <= n_ack;
      m_vec   <= n_vec;
      m_rdata <= n_rdata;
      m_oe    <= n_oe;
      m_phase <= n_phase;
      m_last  <= n_last;
    end
  end

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (live) begin
      chk("m_src_ack", 8'(src_ack), 8'(m_ack));
      chk("m_cpu_raise", 8'(cpu_raise), 8'(m_phase == 1));
      chk("m_bus", bus_data,
          drv ? wdata :
          (m_oe && 8'(addr - BASE) < 8'd4 && !we) ? m_rdata : 8'hFF);
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [1:0] off, logic [7:0] d);
    addr  = BASE + 8'(off);
    we    = 1'b1;
    drv   = 1'b1;
    wdata = d;
    tick(1);
    we    = 1'b0;
    drv   = 1'b0;
    addr  = 8'h00;
  endtask

  task automatic rd(string nm, logic [1:0] off, logic [7:0] exp);
    addr = BASE + 8'(off);
    we   = 1'b0;
    tick(1);
    chk(nm, bus_data, exp);
    addr = 8'h00;
  endtask

  task automatic ack();
    cpu_ack = 1'b1;
    tick(1);
    cpu_ack = 1'b0;
    chk("raise_after_ack", 8'(cpu_raise), 8'h00);
  endtask

`ifdef IRQ_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic [7:0] v;

  initial begin
    // reset with every source requesting
    raise = '1;
    tick(3);
    chk("rst_src_ack", 8'(src_ack), 8'h00);
    chk("rst_cpu_raise", 8'(cpu_raise), 8'h00);
    chk("rst_bus", bus_data, 8'hFF);
    rst_n = 1'b1;
    raise = '0;
    tick(1);

    // single source latency
    wr(2'd0, 8'h0F);
    rd("mask_rd", 2'd0, 8'h0F);
    raise = 4'h4;
    tick(1);
    chk("cap_ack2", 8'(src_ack), 8'h04);
    chk("cap_noraise", 8'(cpu_raise), 8'h00);
    raise = '0;
    tick(1);
    chk("ack_one_pulse", 8'(src_ack), 8'h00);
    chk("raise_2cyc", 8'(cpu_raise), 8'h01);
    rd("pend_04", 2'd1, 8'h04);
    ack();
    rd("vec_82", 2'd2, 8'h82);
    rd("pend_00", 2'd1, 8'h00);
    wr(2'd3, 8'h00);
    tick(2);
    chk("idle_after_eoi", 8'(cpu_raise), 8'h00);
    rd("vec_02", 2'd2, 8'h02);

    // sources 1 and 3 together
    raise = 4'hA;
    tick(1);
    raise = '0;
    tick(1);
    chk("raise_13", 8'(cpu_raise), 8'h01);
    ack();
    rd("vec_first", 2'd2, RR ? 8'h83 : 8'h81);
    rd("pend_left", 2'd1, RR ? 8'h02 : 8'h08);
    wr(2'd3, 8'h00);
    tick(1);
    chk("reraise", 8'(cpu_raise), 8'h01);
    ack();
    rd("vec_second", 2'd2, RR ? 8'h81 : 8'h83);
    wr(2'd3, 8'h00);
    tick(1);

    // masked capture, unmask, W1C drop
    wr(2'd0, 8'h00);
    raise = 4'h1;
    tick(1);
    raise = '0;
    tick(3);
    chk("masked_low", 8'(cpu_raise), 8'h00);
    rd("pend_masked", 2'd1, 8'h01);
    wr(2'd0, 8'h01);
    tick(1);
    chk("unmask_raise", 8'(cpu_raise), 8'h01);
    wr(2'd1, 8'h01);
    tick(1);
    chk("w1c_drop", 8'(cpu_raise), 8'h00);
    rd("pend_w1c", 2'd1, 8'h00);

    // capture beats same-cycle W1C; EOI while idle is ignored
    raise = 4'h2;
    wr(2'd1, 8'h02);
    raise = '0;
    rd("set_wins", 2'd1, 8'h02);
    wr(2'd3, 8'h00);
    rd("eoi_idle_vec", 2'd2, RR ? 8'h01 : 8'h03);
    chk("eoi_idle_low", 8'(cpu_raise), 8'h00);
    wr(2'd1, 8'h02);

    // continuous sources 0 and 1
    wr(2'd0, 8'h03);
    raise = 4'h3;
    for (int i = 0; i < 4; i++) begin
      for (int t = 0; t < 10 && !cpu_raise; t++)
        tick(1);
      chk("wait_raise", 8'(cpu_raise), 8'h01);
      ack();
      v = (RR && i % 2 == 1) ? 8'h81 : 8'h80;
      rd("alt_vec", 2'd2, v);
      wr(2'd3, 8'h00);
    end
    raise = '0;
    tick(3);

    // bus release
    addr = 8'h10;
    tick(2);
    chk("miss_hiz", bus_data, 8'hFF);
    addr = BASE + 8'd2;
    we   = 1'b1;
    tick(2);
    chk("write_hiz", bus_data, 8'hFF);
    we   = 1'b0;
    addr = 8'h00;

    // reset in mid-flight clears everything
    raise = 4'h1;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    chk("rst2_raise", 8'(cpu_raise), 8'h00);
    chk("rst2_ack", 8'(src_ack), 8'h00);
    rst_n = 1'b1;
    raise = '0;
    rd("rst2_mask", 2'd0, 8'h00);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
